// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing for the instruction-memory loader
package imem_loader_pkg;

    localparam int SIZE_INST_DEF = 5;
    localparam int LEN_W         = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a byte stream into little-endian 32-bit words
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [1:0]  idx,
    output logic [31:0] word,
    output logic        word_valid
);

    // Bytes enter at the top and shift down, so the first byte of a word ends in bits 7:0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && idx == 2'd3;
            if (byte_en) begin
                idx  <= idx + 2'd1;
                word <= {byte_in, word[31:8]};
            end
        end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a checksummed byte-stream program image into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SIZE_INST = SIZE_INST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 wr_en,
    output logic [SIZE_INST-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err,
    output logic [SIZE_INST:0]   words_loaded
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << SIZE_INST);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [7:0]       csum;
    logic [1:0]       idx;
    logic             word_valid;
    logic             xfer;
    logic             clr;
    logic             byte_en;
    logic [LEN_W-1:0] len_in;

    assign xfer    = rx_valid && rx_ready;
    assign clr     = state == IDLE && load_start;
    assign byte_en = xfer && state == DATA;
    assign len_in  = {rx_data, len[7:0]};
    assign wr_en   = word_valid;
    assign wr_addr = words_loaded[SIZE_INST-1:0];

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .idx        (idx),
        .word       (wr_data),
        .word_valid (word_valid)
    );

    // Session FSM: outputs change on the transition so they line up with the new state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            csum         <= '0;
        end else begin
            done <= 1'b0;
            if (word_valid)
                words_loaded <= words_loaded + 1'b1;
            case (state)
                IDLE:
                    if (load_start) begin
                        state        <= LEN_LO;
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        csum         <= '0;
                        len          <= '0;
                    end
                LEN_LO:
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        state    <= LEN_HI;
                    end
                LEN_HI:
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        if (len_in > DEPTH) begin
                            err      <= 1'b1;
                            state    <= FIN;
                            rx_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else
                            state <= len_in == '0 ? CSUM : DATA;
                    end
                DATA:
                    if (xfer) begin
                        csum <= csum + rx_data;
                        if (idx == 2'd3) begin
                            len <= len - 1'b1;
                            if (len == LEN_W'(1))
                                state <= CSUM;
                        end
                    end
                CSUM:
                    if (xfer) begin
                        if (rx_data != csum)
                            err <= 1'b1;
                        state    <= FIN;
                        rx_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end
                FIN:
                    state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a byte-image model
module tb_imem_loader;

    localparam int SI = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          wr_en;
    logic [SI-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [SI:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int hold_bad = 0;
    bit sess = 1'b0;
    logic [7:0]  img[$];
    logic [36:0] wq[$];

    imem_loader #(.SIZE_INST(SI)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every memory write; flag cpu_hold dropping mid-session or overlapping done
    always @(negedge clk) begin
        if (wr_en)
            wq.push_back({wr_addr, wr_data});
        if ((sess && !cpu_hold && !done) || (done && cpu_hold))
            hold_bad++;
    end

    task automatic check_reset(input string tag);
        check({tag, ":rx_ready"}, rx_ready, 0);
        check({tag, ":wr_en"}, wr_en, 0);
        check({tag, ":cpu_hold"}, cpu_hold, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":err"}, err, 0);
        check({tag, ":wr_addr"}, wr_addr, 0);
        check({tag, ":wr_data"}, wr_data, 0);
        check({tag, ":words"}, words_loaded, 0);
    endtask

    task automatic nominal(input logic [7:0] cs);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, cs};
    endtask

    task automatic build(input int cnt, input bit bad);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        img.delete();
        img.push_back(8'(cnt));
        img.push_back(8'(cnt >> 8));
        if (cnt <= (1 << SI)) begin
            for (int i = 0; i < 4 * cnt; i++) begin
                b = 8'($urandom);
                img.push_back(b);
                s = s + b;
            end
            img.push_back(bad ? s + 8'd1 : s);
        end
    endtask

    task automatic start();
        @(negedge clk);
        rx_valid   = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int n;
        repeat (gap) begin
            @(negedge clk);
            rx_valid   = 1'b0;
            rx_data    = 8'($urandom);
            load_start = 1'b0;
        end
        @(negedge clk);
        rx_valid   = 1'b1;
        rx_data    = b;
        load_start = pulse;
        n = 0;
        while (!rx_ready && n < 64) begin
            @(negedge clk);
            load_start = 1'b0;
            n++;
        end
        check("rx_ready_wait", n < 64, 1);
        @(posedge clk);
    endtask

    task automatic run_session(input string nm, input bit gaps, input bit extra);
        int          cnt;
        int          ncons;
        int          k;
        bit          over;
        bit          exp_err;
        logic [7:0]  sum;
        logic [31:0] w;
        logic [36:0] exp_q[$];
        cnt  = int'({img[1], img[0]});
        over = cnt > (1 << SI);
        exp_q.delete();
        if (over) begin
            exp_err = 1'b1;
            ncons   = 2;
        end else begin
            sum = 8'h00;
            for (int i = 0; i < cnt; i++) begin
                w = {img[2 + 4*i + 3], img[2 + 4*i + 2], img[2 + 4*i + 1], img[2 + 4*i]};
                exp_q.push_back({SI'(i), w});
                for (int j = 0; j < 4; j++)
                    sum = sum + img[2 + 4*i + j];
            end
            exp_err = img[2 + 4*cnt] != sum;
            ncons   = 3 + 4 * cnt;
        end
        wq.delete();
        start();
        check({nm, ":hold_on"}, cpu_hold, 1);
        check({nm, ":err_clr"}, err, 0);
        check({nm, ":words_clr"}, words_loaded, 0);
        sess = 1'b1;
        for (int i = 0; i < ncons; i++)
            send_byte(img[i], gaps ? int'($urandom_range(0, 5)) : 0, extra && $urandom_range(0, 2) == 0);
        k = 0;
        do begin
            @(negedge clk);
            load_start = 1'b0;
            k++;
        end while (!done && k < 4);
        check({nm, ":done"}, done, 1);
        if (over)
            check({nm, ":done_latency"}, k <= 2, 1);
        check({nm, ":err_at_done"}, err, exp_err);
        check({nm, ":words_at_done"}, words_loaded, over ? 0 : cnt);
        check({nm, ":hold_at_done"}, cpu_hold, 0);
        check({nm, ":ready_at_done"}, rx_ready, 0);
        sess       = 1'b0;
        load_start = extra;
        rx_valid   = 1'b1;
        rx_data    = 8'($urandom);
        @(negedge clk);
        load_start = 1'b0;
        check({nm, ":done_pulse"}, done, 0);
        check({nm, ":idle_hold"}, cpu_hold, 0);
        repeat (2) @(negedge clk);
        check({nm, ":idle_ready"}, rx_ready, 0);
        rx_valid = 1'b0;
        check({nm, ":err_sticky"}, err, exp_err);
        check({nm, ":n_writes"}, wq.size(), exp_q.size());
        foreach (exp_q[i])
            check({nm, ":write"}, (i < wq.size()) ? 64'(wq[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_q[i]));
        check({nm, ":hold_profile"}, hold_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 check_reset("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        nominal(8'hB6);
        run_session("nominal", 0, 0);
        check("nominal:w0", wq.size() > 0 ? 64'(wq[0]) : 64'hFFFF_FFFF_FFFF_FFFF, {27'd0, 5'd0, 32'h0000_0013});
        check("nominal:w1", wq.size() > 1 ? 64'(wq[1]) : 64'hFFFF_FFFF_FFFF_FFFF, {27'd0, 5'd1, 32'h0010_0093});

        img = '{8'h00, 8'h00, 8'h00};
        run_session("empty", 0, 0);
        img = '{8'h21, 8'h00};
        run_session("over33", 0, 0);
        img = '{8'h00, 8'h01};
        run_session("over256", 0, 1);
        build(32, 0);
        run_session("max32", 0, 0);

        nominal(8'hB7);
        run_session("bad_csum", 0, 0);
        nominal(8'hB6);
        run_session("reload", 0, 0);
        nominal(8'hB6);
        run_session("gaps", 1, 1);

        for (int r = 0; r < 8; r++) begin
            build(int'($urandom_range(0, 34)), $urandom_range(0, 3) == 0);
            run_session("random", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        nominal(8'hB6);
        start();
        for (int i = 0; i < 8; i++)
            send_byte(img[i], 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        check("mid:words_before", words_loaded, 1);
        check("mid:hold_before", cpu_hold, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        nominal(8'hB6);
        run_session("post_reset", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
